// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//   Issue stage in front of the shifter of the reduced 16-bit ARM datapath.
//   Takes one Thumb-style shift instruction per valid/ready handshake, reads
//   its operands from an internal 8x16 register file (with write-back
//   bypass), decodes aBus / imm5 / shift_op / rd_addr and presents them on a
//   registered valid/ready output backed by a one-entry skid buffer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     upstream handshake, instr is the instruction word
//   wb_en/addr/data       register-file write port (never stalled)
//   out_valid/ready       downstream handshake toward the shifter
//   aBus, imm5, shift_op  shifter operands, rd_addr destination register
//   illegal               one-cycle pulse after an illegal word is consumed
module shift_issue_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    input  logic          wb_en,
    input  logic [2:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] aBus,
    output logic [DW-1:0] imm5,
    output logic [4:0]    shift_op,
    output logic [2:0]    rd_addr,
    output logic          illegal
);

    typedef struct packed {
        logic [DW-1:0] abus;
        logic [DW-1:0] imm;
        logic [4:0]    op;
        logic [2:0]    rd;
    } entry_t;

    logic [DW-1:0] rf_q [NREGS];
    logic [DW-1:0] rf_d [NREGS];

    entry_t out_q, out_d, skid_q, skid_d, dec;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   illegal_q, illegal_d;

    logic [DW-1:0] src_hi, src_lo;
    logic          dec_legal, accept, push;

    // Operand read with same-cycle write-back bypass; instr[5:3] and
    // instr[2:0] are bypassed independently.
    always_comb begin
        src_hi = (wb_en && (wb_addr == instr[5:3])) ? wb_data : rf_q[instr[5:3]];
        src_lo = (wb_en && (wb_addr == instr[2:0])) ? wb_data : rf_q[instr[2:0]];
    end

    always_comb begin
        dec_legal = 1'b0;
        dec.abus  = '0;
        dec.imm   = '0;
        dec.op    = '0;
        dec.rd    = instr[2:0];
        if ((instr[15:13] == 3'b000) && (instr[12:11] != 2'b11)) begin
            dec_legal = 1'b1;
            case (instr[12:11])
                2'b00:   dec.op = 5'b01000;
                2'b01:   dec.op = 5'b01010;
                default: dec.op = 5'b01110;
            endcase
            dec.abus = src_hi;
            dec.imm  = DW'(instr[10:6]);
        end else if (instr[15:6] == 10'b0100000111) begin
            dec_legal = 1'b1;
            dec.op    = 5'b10110;
            dec.abus  = src_lo;
            dec.imm   = DW'(src_hi[4:0]);
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Output/skid pair: the skid only fills while the output is stalled, and
    // when the output frees up the skid always refills it first, so entries
    // leave in acceptance order. No accept is possible while the skid is full.
    always_comb begin
        accept       = instr_valid && !skid_valid_q;
        push         = accept && dec_legal;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        illegal_d    = accept && !dec_legal;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign instr_ready = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign aBus        = out_q.abus;
    assign imm5        = out_q.imm;
    assign shift_op    = out_q.op;
    assign rd_addr     = out_q.rd;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] aBus;
    logic [15:0] imm5;
    logic [4:0]  shift_op;
    logic [2:0]  rd_addr;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    shift_issue_stage #(.NREGS(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .aBus(aBus), .imm5(imm5), .shift_op(shift_op), .rd_addr(rd_addr),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        legal;
        logic [15:0] abus;
        logic [15:0] imm;
        logic [4:0]  op;
        logic [2:0]  rd;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [15:0] ins;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] ei;
        logic [4:0]  eo;
        logic [2:0]  er;
        logic        eill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] a, input logic [15:0] i,
                           input logic [4:0] o, input logic [2:0] r);
        chk({tag, ".aBus"}, 32'(aBus), 32'(a));
        chk({tag, ".imm5"}, 32'(imm5), 32'(i));
        chk({tag, ".shift_op"}, 32'(shift_op), 32'(o));
        chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(r));
    endtask

    // Reference decoder: ra = value of register w[5:3], rb = value of w[2:0]
    // (bypass already resolved by the caller).
    function automatic exp_t ref_decode(input logic [15:0] w, input logic [15:0] ra,
                                        input logic [15:0] rb);
        exp_t e;
        int   fmt_op;
        e.legal = 1'b0; e.abus = 0; e.imm = 0; e.op = 0; e.rd = 3'(w % 8);
        fmt_op = int'(w / 2048);          // instr[15:11]
        if (fmt_op < 3) begin
            e.legal = 1'b1;
            e.op    = (fmt_op == 0) ? 5'd8 : (fmt_op == 1) ? 5'd10 : 5'd14;
            e.abus  = ra;
            e.imm   = 16'((w / 64) % 32);
        end else if (int'(w / 64) == 'h107) begin
            e.legal = 1'b1;
            e.op    = 5'd22;
            e.abus  = rb;
            e.imm   = 16'(ra % 32);
        end
        return e;
    endfunction

    task automatic idle_inputs();
        instr_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t        tbl[10];
    logic [15:0] mreg[8];
    exp_t        q[$];
    logic        exp_ill;

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.instr_ready", 32'(instr_ready), 1);
        chk("rst.illegal", 32'(illegal), 0);
        chk_out("rst", 16'h0, 16'h0, 5'h0, 3'h0);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        //          iv  ins       we  wa  wd        ev  ea        ei  eo     er  ill
        tbl[0] = '{0, 16'h0000, 1, 1, 16'hF084, 0, 16'h0000, 0,  5'h00, 0, 0};
        tbl[1] = '{1, 16'h00CA, 0, 0, 16'h0000, 1, 16'hF084, 3,  5'h08, 2, 0};
        tbl[2] = '{1, 16'h0FC8, 0, 0, 16'h0000, 1, 16'hF084, 31, 5'h0A, 0, 0};
        tbl[3] = '{1, 16'h1008, 1, 3, 16'h0025, 1, 16'hF084, 0,  5'h0E, 0, 0};
        tbl[4] = '{1, 16'h41D9, 0, 0, 16'h0000, 1, 16'hF084, 5,  5'h16, 1, 0};
        tbl[5] = '{1, 16'h00CA, 1, 1, 16'h1234, 1, 16'h1234, 3,  5'h08, 2, 0};
        tbl[6] = '{1, 16'h1800, 0, 0, 16'h0000, 0, 16'h0000, 0,  5'h00, 0, 1};
        tbl[7] = '{1, 16'h41DB, 1, 3, 16'h0047, 1, 16'h0047, 7,  5'h16, 3, 0};
        tbl[8] = '{1, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0000, 0,  5'h00, 0, 1};
        tbl[9] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0,  5'h00, 0, 0};
        for (int k = 0; k < 10; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            instr_valid = tbl[k].iv; instr = tbl[k].ins;
            wb_en = tbl[k].we; wb_addr = tbl[k].wa; wb_data = tbl[k].wd;
            @(negedge clk);
            idle_inputs();
            chk({tag, ".out_valid"}, 32'(out_valid), 32'(tbl[k].ev));
            chk({tag, ".illegal"}, 32'(illegal), 32'(tbl[k].eill));
            if (tbl[k].ev) chk_out(tag, tbl[k].ea, tbl[k].ei, tbl[k].eo, tbl[k].er);
        end
        // illegal is a single-cycle pulse
        instr_valid = 1'b1; instr = 16'h1800;
        @(negedge clk);
        idle_inputs();
        chk("ill.pulse", 32'(illegal), 1);
        @(negedge clk);
        chk("ill.drop", 32'(illegal), 0);
        chk("ill.out_valid", 32'(out_valid), 0);

        // ---------------- backpressure: three entries, FIFO order ----------------
        out_ready = 1'b0;
        instr_valid = 1'b1; instr = 16'h00CA;        // A: LSL #3, R1 (=1234)
        @(negedge clk);
        chk("bp.A.valid", 32'(out_valid), 1);
        chk("bp.A.ready", 32'(instr_ready), 1);
        chk_out("bp.A", 16'h1234, 3, 5'h08, 2);
        instr = 16'h0FC8;                             // B -> skid
        @(negedge clk);
        chk("bp.full.ready", 32'(instr_ready), 0);
        chk_out("bp.A.hold", 16'h1234, 3, 5'h08, 2);
        instr = 16'h1008;                             // C offered, refused
        @(negedge clk);
        chk("bp.still.ready", 32'(instr_ready), 0);
        chk_out("bp.A.hold2", 16'h1234, 3, 5'h08, 2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.B.valid", 32'(out_valid), 1);
        chk("bp.B.ready", 32'(instr_ready), 1);
        chk_out("bp.B", 16'h1234, 31, 5'h0A, 0);
        @(negedge clk);                               // C accepted on the prior edge
        idle_inputs();
        chk("bp.C.valid", 32'(out_valid), 1);
        chk_out("bp.C", 16'h1234, 0, 5'h0E, 0);
        @(negedge clk);
        chk("bp.empty", 32'(out_valid), 0);

        // ---------------- reset with skid full ----------------
        out_ready = 1'b0;
        instr_valid = 1'b1; instr = 16'h00CA;
        repeat (2) @(negedge clk);
        idle_inputs();
        chk("rs.full.ready", 32'(instr_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rs.out_valid", 32'(out_valid), 0);
        chk("rs.instr_ready", 32'(instr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        instr_valid = 1'b1; instr = 16'h41D9;         // reads R3, R1 after reset
        @(negedge clk);
        idle_inputs();
        chk("rs.regs.valid", 32'(out_valid), 1);
        chk_out("rs.regs", 16'h0, 0, 5'h16, 1);

        // ---------------- randomized, against queue model ----------------
        do_reset();
        for (int r = 0; r < 8; r++) mreg[r] = '0;
        q.delete();
        exp_ill = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_t        e;
            logic [15:0] w, ra, rb;
            logic        acc;
            int          kind;
            @(negedge clk);
            chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd.instr_ready", 32'(instr_ready), 32'(q.size() < 2));
            chk("rnd.illegal", 32'(illegal), 32'(exp_ill));
            if (q.size() > 0) chk_out("rnd", q[0].abus, q[0].imm, q[0].op, q[0].rd);

            kind = int'($urandom_range(0, 3));
            case (kind)
                0, 1:    w = 16'($urandom_range(0, 16'h17FF));
                2:       w = 16'h41C0 | 16'($urandom_range(0, 63));
                default: w = 16'($urandom);
            endcase
            instr_valid = ($urandom_range(0, 3) != 0);
            instr       = w;
            out_ready   = ($urandom_range(0, 2) != 0);
            wb_en       = $urandom_range(0, 1) == 1;
            wb_addr     = 3'($urandom_range(0, 7));
            wb_data     = 16'($urandom);

            ra  = (wb_en && wb_addr == w[5:3]) ? wb_data : mreg[w[5:3]];
            rb  = (wb_en && wb_addr == w[2:0]) ? wb_data : mreg[w[2:0]];
            e   = ref_decode(w, ra, rb);
            acc = instr_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc && e.legal) q.push_back(e);
            exp_ill = acc && !e.legal;
            if (wb_en) mreg[wb_addr] = wb_data;
        end
        @(negedge clk);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
